// File: rtl/delay_timer_pkg.sv
// Shared definitions for the programmable delay/tick timer: FSM states,
// mode encodings and the prescaler width helper.
package delay_timer_pkg;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    localparam logic TMR_ONESHOT  = 1'b0;
    localparam logic TMR_PERIODIC = 1'b1;

    // A divide-by-one prescaler still needs a legal one-bit counter width.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/delay_timer_if.sv
// Control/status bundle between a timer client (master) and the delay timer (slave).
interface delay_timer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] period;
    logic             periodic;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remaining;

    modport master (
        output start, period, periodic, abort,
        input  busy, done, remaining
    );

    modport slave (
        input  start, period, periodic, abort,
        output busy, done, remaining
    );
endinterface

// File: rtl/delay_timer_prescaler.sv
// Clock divider producing one tick every PRESCALE clk cycles; clr restarts
// the division so the first tick of a run lands PRESCALE edges after start.
module tick_prescaler
    import delay_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr};
            assign tick = 1'b1;
        end else begin : g_div
            localparam int            CW   = prescale_width(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign tick = (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/delay_timer.sv
// Programmable one-shot/periodic delay timer with prescaler, abort and retrigger.
// Holds the IDLE/RUN FSM, latched period and mode, remaining count and done pulse.
module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic          clk,
    input  logic          rst,
    delay_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    tmr_state_e       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             load;
    logic             tick;
    logic [WIDTH-1:0] start_p;

    assign start_p = (bus.period == '0) ? ONE : bus.period;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= TMR_IDLE;
            p_q     <= '0;
            mode_q  <= TMR_ONESHOT;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Priority abort > start > expiry; a retrigger swallows any expiry on its edge.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        load    = 1'b0;

        if (bus.abort) begin
            state_d = TMR_IDLE;
            rem_d   = '0;
        end else if (bus.start) begin
            load    = 1'b1;
            state_d = TMR_RUN;
            p_d     = start_p;
            mode_d  = bus.periodic;
            rem_d   = start_p;
        end else begin
            case (state_q)
                TMR_RUN: begin
                    if (tick) begin
                        if (rem_q <= ONE) begin
                            done_d = 1'b1;
                            if (mode_q == TMR_PERIODIC) begin
                                rem_d = p_q;
                            end else begin
                                state_d = TMR_IDLE;
                                rem_d   = '0;
                            end
                        end else begin
                            rem_d = rem_q - ONE;
                        end
                    end
                end
                default: begin
                    state_d = TMR_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q == TMR_RUN);
    assign bus.done      = done_q;
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_delay_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) share one stimulus stream and
// are compared every cycle against an elapsed-time model, plus literal spot checks.
module tb_delay_timer;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] period   = '0;
    logic        periodic = 1'b0;
    logic        abort    = 1'b0;

    int checks = 0;
    int errors = 0;

    delay_timer_if #(.WIDTH(16)) bus1 ();
    delay_timer_if #(.WIDTH(16)) bus4 ();

    assign bus1.start    = start;
    assign bus1.period   = period;
    assign bus1.periodic = periodic;
    assign bus1.abort    = abort;
    assign bus4.start    = start;
    assign bus4.period   = period;
    assign bus4.periodic = periodic;
    assign bus4.abort    = abort;

    delay_timer #(.WIDTH(16), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    delay_timer #(.WIDTH(16), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    logic [1:0]  a_busy;
    logic [1:0]  a_done;
    logic [15:0] a_rem [2];

    assign a_busy[0] = bus1.busy;
    assign a_busy[1] = bus4.busy;
    assign a_done[0] = bus1.done;
    assign a_done[1] = bus4.done;
    assign a_rem[0]  = bus1.remaining;
    assign a_rem[1]  = bus4.remaining;

    // Model: a run is described by its start edge, period and mode; outputs
    // follow from elapsed edges divided by the prescale factor.
    int ps [2] = '{1, 4};
    int n = 0;
    bit m_run [2];
    bit m_per [2];
    int m_e0  [2];
    int m_p   [2];
    bit e_busy [2];
    bit e_done [2];
    int e_rem  [2];

    task automatic modelStep();
        int k;
        n++;
        for (int i = 0; i < 2; i++) begin
            e_done[i] = 1'b0;
            if (!rst) begin
                m_run[i] = 1'b0;
            end else if (abort) begin
                m_run[i] = 1'b0;
            end else if (start) begin
                m_run[i] = 1'b1;
                m_e0[i]  = n;
                m_p[i]   = (period == 16'd0) ? 1 : int'(period);
                m_per[i] = periodic;
            end else if (m_run[i]) begin
                k = n - m_e0[i];
                if ((k % ps[i]) == 0 && ((k / ps[i]) % m_p[i]) == 0) begin
                    e_done[i] = 1'b1;
                    if (!m_per[i]) m_run[i] = 1'b0;
                end
            end
            e_busy[i] = m_run[i];
            e_rem[i]  = m_run[i] ? (m_p[i] - ((n - m_e0[i]) / ps[i]) % m_p[i]) : 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (a_busy[i] !== e_busy[i] || a_done[i] !== e_done[i] || int'(a_rem[i]) != e_rem[i]) begin
                    errors++;
                    $display("[TB] FAIL model_dut%0d edge %0d: busy/done/rem got %0b/%0b/%0d expected %0b/%0b/%0d",
                             i, n, a_busy[i], a_done[i], a_rem[i], e_busy[i], e_done[i], e_rem[i]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Presents one edge of control inputs, then drops the pulses; returns at the
    // negedge right after that edge so its registered effect is visible.
    task automatic applyStimulus(input logic s, input logic [15:0] p, input logic per, input logic a);
        @(negedge clk);
        start    = s;
        period   = p;
        periodic = per;
        abort    = a;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int rel;
        int last;
        int cnt;

        $display("[TB] reset with start held");
        rst    = 1'b0;
        start  = 1'b1;
        period = 16'd5;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_busy", int'(bus1.busy), 0);
            checkOutput("rst_done", int'(bus1.done), 0);
            checkOutput("rst_rem", int'(bus1.remaining), 0);
        end
        start = 1'b0;
        rst   = 1'b1;

        $display("[TB] one-shot period 6");
        applyStimulus(1'b1, 16'd6, 1'b0, 1'b0);
        checkOutput("os_rem_e0", int'(bus1.remaining), 6);
        checkOutput("os_busy_e0", int'(bus1.busy), 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checkOutput("os_rem", int'(bus1.remaining), 6 - i);
            checkOutput("os_done_early", int'(bus1.done), 0);
        end
        @(negedge clk);
        checkOutput("os_done", int'(bus1.done), 1);
        checkOutput("os_busy_end", int'(bus1.busy), 0);
        checkOutput("os_rem_end", int'(bus1.remaining), 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus1.done) cnt++;
        end
        checkOutput("os_no_more_done", cnt, 0);

        $display("[TB] periodic period 3 prescale 4");
        applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
        rel  = 0;
        last = 0;
        for (int e = 0; e < 5; e++) begin
            do begin
                @(negedge clk);
                rel++;
            end while (!bus4.done && (rel - last) < 40);
            checkOutput("per_interval", rel - last, 12);
            checkOutput("per_busy", int'(bus4.busy), 1);
            last = rel;
            if (e == 1) period = 16'd9;
        end
        applyStimulus(1'b0, 16'd9, 1'b0, 1'b1);
        checkOutput("per_abort_busy", int'(bus4.busy), 0);

        $display("[TB] boundary periods");
        applyStimulus(1'b1, 16'd0, 1'b0, 1'b0);
        checkOutput("p0_rem", int'(bus1.remaining), 1);
        @(negedge clk);
        checkOutput("p0_done", int'(bus1.done), 1);
        checkOutput("p0_busy", int'(bus1.busy), 0);
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
        rel = 0;
        do begin
            @(negedge clk);
            rel++;
        end while (!bus1.done && rel < 70000);
        checkOutput("pmax_latency", rel, 65535);

        $display("[TB] abort and retrigger");
        applyStimulus(1'b1, 16'd10, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("ab_rem_before", int'(bus1.remaining), 4);
        applyStimulus(1'b0, 16'd10, 1'b0, 1'b1);
        checkOutput("ab_busy", int'(bus1.busy), 0);
        checkOutput("ab_rem", int'(bus1.remaining), 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus1.done) cnt++;
        end
        checkOutput("ab_no_done", cnt, 0);

        applyStimulus(1'b1, 16'd10, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        checkOutput("rt_rem_before", int'(bus1.remaining), 1);
        applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
        checkOutput("rt_done_suppressed", int'(bus1.done), 0);
        checkOutput("rt_rem", int'(bus1.remaining), 5);
        rel = 0;
        do begin
            @(negedge clk);
            rel++;
        end while (!bus1.done && rel < 20);
        checkOutput("rt_latency", rel, 5);

        applyStimulus(1'b1, 16'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd7, 1'b0, 1'b1);
        checkOutput("abst_run_busy", int'(bus1.busy), 0);
        checkOutput("abst_run_rem", int'(bus1.remaining), 0);
        applyStimulus(1'b1, 16'd7, 1'b0, 1'b1);
        checkOutput("abst_idle_busy", int'(bus1.busy), 0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 16'd8, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("mr_rem_before", int'(bus1.remaining), 3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mr_busy", int'(bus1.busy), 0);
        checkOutput("mr_done", int'(bus1.done), 0);
        checkOutput("mr_rem", int'(bus1.remaining), 0);
        rst = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus1.done || bus1.busy) cnt++;
        end
        checkOutput("mr_quiet_after", cnt, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
